// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline memory stage: access FSM states and
// the default data-memory base address.
package arm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

endpackage

// File: rtl/sram_phase_timer.sv
// Per-phase cycle counter for the SRAM access FSM. load_i restarts the count at
// the start of a phase; the count saturates once the phase's last cycle is hit.
module sram_phase_timer #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic last_cycle_o,
    output logic we_active_o
);

    localparam logic [3:0] LAST_COUNT = 4'(WAIT_CYCLES);

    logic [2:0] count_q;
    logic [2:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = 3'd0;
        end else if (!last_cycle_o) begin
            count_d = count_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_cycle_o = ({1'b0, count_q} == LAST_COUNT);
    // True when the write strobe should stay asserted in the following cycle of this phase.
    assign we_active_o  = (({1'b0, count_q} + 4'd1) < LAST_COUNT);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: splits each 32-bit load/store into two 16-bit async SRAM
// phases. Optional last-read buffer enabled by MEM_ACCESS_CTRL_LAST_READ_EN.
module mem_access_ctrl
    import arm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        ALU_result,
    input  logic [31:0]        Val_Rm,
    output logic [31:0]        rd_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    inout  wire  [15:0]        SRAM_DQ,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N
);

    localparam int IW = SRAM_AW - 1;

    mem_state_e         state_q;
    logic               store_q;
    logic [IW-1:0]      index_q;
    logic [15:0]        wdata_hi_q;
    logic [SRAM_AW-1:0] addr_q;
    logic               we_n_q;
    logic               oe_n_q;
    logic               dq_oe_q;
    logic [15:0]        dq_out_q;
    logic [31:0]        rd_data_q;

    logic [31:0]   off;
    logic [IW-1:0] req_index;
    logic          req;
    logic          hit;
    logic          start;
    logic          phase_load;
    logic          last_cycle;
    logic          we_active;
    logic          unused_off;

    // Byte offset wraps modulo 2^32; only the word-index bits reach the SRAM.
    assign off        = ALU_result - BASE_ADDR;
    assign req_index  = off[SRAM_AW:2];
    assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};

    assign req        = MEM_R_EN | MEM_W_EN;
    assign start      = (state_q == IDLE) & req & ~hit;
    assign phase_load = start | ((state_q == LO) & last_cycle);

    sram_phase_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .load_i       (phase_load),
        .last_cycle_o (last_cycle),
        .we_active_o  (we_active)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            store_q    <= 1'b0;
            index_q    <= '0;
            wdata_hi_q <= '0;
            addr_q     <= '0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
            dq_out_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // A simultaneous read+write request is performed as a store.
                        state_q    <= LO;
                        store_q    <= MEM_W_EN;
                        index_q    <= req_index;
                        wdata_hi_q <= Val_Rm[31:16];
                        addr_q     <= {req_index, 1'b0};
                        we_n_q     <= ~MEM_W_EN;
                        oe_n_q     <= MEM_W_EN;
                        dq_oe_q    <= MEM_W_EN;
                        dq_out_q   <= Val_Rm[15:0];
                    end else if (hit) begin
                        rd_data_q  <= rd_data;
                    end
                end
                LO: begin
                    if (last_cycle) begin
                        state_q  <= HI;
                        addr_q   <= {index_q, 1'b1};
                        dq_out_q <= wdata_hi_q;
                        we_n_q   <= ~store_q;
                        if (!store_q) begin
                            rd_data_q[15:0] <= SRAM_DQ;
                        end
                    end else begin
                        we_n_q <= ~(store_q & we_active);
                    end
                end
                HI: begin
                    if (last_cycle) begin
                        state_q <= DONE;
                        we_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                        if (!store_q) begin
                            rd_data_q[31:16] <= SRAM_DQ;
                        end
                    end else begin
                        we_n_q <= ~(store_q & we_active);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ACCESS_CTRL_LAST_READ_EN
    logic          buf_valid_q;
    logic [IW-1:0] buf_index_q;
    logic [31:0]   buf_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_index_q <= '0;
            buf_data_q  <= '0;
        end else if (start & MEM_W_EN) begin
            buf_valid_q <= 1'b0;
        end else if ((state_q == DONE) & ~store_q) begin
            buf_valid_q <= 1'b1;
            buf_index_q <= index_q;
            buf_data_q  <= rd_data_q;
        end
    end

    assign hit     = (state_q == IDLE) & MEM_R_EN & ~MEM_W_EN & buf_valid_q
                     & (buf_index_q == req_index);
    assign rd_data = hit ? buf_data_q : rd_data_q;
`else
    assign hit     = 1'b0;
    assign rd_data = rd_data_q;
`endif

    assign ready     = (state_q == DONE) | ((state_q == IDLE) & ~req) | hit;
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural async SRAM; the
// last-read buffer checks run when MEM_ACCESS_CTRL_LAST_READ_EN is defined.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_result;
    logic [31:0] Val_Rm;
    logic [31:0] rd_data;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    logic        SRAM_WE_N;
    logic        SRAM_OE_N;

    logic [15:0] mem [0:(1<<18)-1];
    logic        probe_en = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .BASE_ADDR   (32'd1024),
        .SRAM_AW     (18),
        .WAIT_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (MEM_R_EN),
        .MEM_W_EN   (MEM_W_EN),
        .ALU_result (ALU_result),
        .Val_Rm     (Val_Rm),
        .rd_data    (rd_data),
        .ready      (ready),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_DQ    (SRAM_DQ),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_OE_N  (SRAM_OE_N)
    );

    // SRAM model: reads drive the bus while OE_N is low; writes land while WE_N is low.
    assign SRAM_DQ = (!SRAM_OE_N) ? mem[SRAM_ADDR] : 16'hzzzz;
    assign SRAM_DQ = probe_en ? 16'hA5A5 : 16'hzzzz;

    always @(posedge clk) begin
        if (!SRAM_WE_N) begin
            mem[SRAM_ADDR] <= SRAM_DQ;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Starts at a negedge; records cycles 0..5 of the access and returns at the cycle-6 negedge.
    task automatic run_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                              output logic [5:0] rdy_v, output logic [5:0] oe_v, output logic [5:0] we_v,
                              output logic [17:0] addr1, output logic [17:0] addr3, output logic [31:0] rd5);
        MEM_R_EN   = r;
        MEM_W_EN   = w;
        ALU_result = a;
        Val_Rm     = d;
        addr1 = '0;
        addr3 = '0;
        rd5   = '0;
        for (int c = 0; c < 6; c++) begin
            #1;
            rdy_v[c] = ready;
            oe_v[c]  = SRAM_OE_N;
            we_v[c]  = SRAM_WE_N;
            if (c == 1) addr1 = SRAM_ADDR;
            if (c == 3) addr3 = SRAM_ADDR;
            if (c == 5) begin
                rd5      = rd_data;
                MEM_R_EN = 1'b0;
                MEM_W_EN = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic probe_bus(input string tag);
        probe_en = 1'b1;
        #1;
        check(tag, {16'h0, SRAM_DQ}, 32'h0000A5A5);
        probe_en = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0]  rdy_v, oe_v, we_v;
        logic [17:0] a1, a3;
        logic [31:0] rd5;

        rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; ALU_result = '0; Val_Rm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", {31'h0, ready}, 32'd1);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_we_n", {31'h0, SRAM_WE_N}, 32'd1);
        check("rst_oe_n", {31'h0, SRAM_OE_N}, 32'd1);
        check("rst_addr", {14'h0, SRAM_ADDR}, 32'h0);
        probe_bus("rst_dq_hiz");

        // Idle bus: no request, no strobes over a few cycles.
        @(negedge clk); @(negedge clk);
        #1;
        check("idle_oe_n", {31'h0, SRAM_OE_N}, 32'd1);
        check("idle_we_n", {31'h0, SRAM_WE_N}, 32'd1);
        @(negedge clk);

        // Reset arriving during the HI phase of a store.
        MEM_W_EN = 1'b1; ALU_result = 32'd1040; Val_Rm = 32'h0BADCAFE;
        repeat (3) @(negedge clk);
        #1;
        check("hi_we_n_low", {31'h0, SRAM_WE_N}, 32'd0);
        check("hi_addr", {14'h0, SRAM_ADDR}, 32'd9);
        rst = 1'b1; MEM_W_EN = 1'b0;
        @(negedge clk);
        #1;
        check("abort_ready", {31'h0, ready}, 32'd1);
        check("abort_we_n", {31'h0, SRAM_WE_N}, 32'd1);
        check("abort_oe_n", {31'h0, SRAM_OE_N}, 32'd1);
        probe_bus("abort_dq_hiz");
        rst = 1'b0;
        @(negedge clk);

        // Store 0xDEADBEEF at 1028 -> SRAM words 2 and 3.
        run_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, rdy_v, oe_v, we_v, a1, a3, rd5);
        check("st_ready_vec", {26'h0, rdy_v}, 32'b100000);
        check("st_we_vec", {26'h0, we_v}, 32'b110101);
        check("st_oe_vec", {26'h0, oe_v}, 32'b111111);
        check("st_addr_lo", {14'h0, a1}, 32'd2);
        check("st_addr_hi", {14'h0, a3}, 32'd3);
        check("st_mem2", {16'h0, mem[2]}, 32'h0000BEEF);
        check("st_mem3", {16'h0, mem[3]}, 32'h0000DEAD);

        // Load it back.
        run_access(1'b1, 1'b0, 32'd1028, 32'h0, rdy_v, oe_v, we_v, a1, a3, rd5);
        check("ld_ready_vec", {26'h0, rdy_v}, 32'b100000);
        check("ld_oe_vec", {26'h0, oe_v}, 32'b100001);
        check("ld_we_vec", {26'h0, we_v}, 32'b111111);
        check("ld_addr_lo", {14'h0, a1}, 32'd2);
        check("ld_rd_data", rd5, 32'hDEADBEEF);

        // Both enables: performed as a store, rd_data untouched.
        run_access(1'b1, 1'b1, 32'd1032, 32'h12345678, rdy_v, oe_v, we_v, a1, a3, rd5);
        check("both_ready_vec", {26'h0, rdy_v}, 32'b100000);
        check("both_mem4", {16'h0, mem[4]}, 32'h00005678);
        check("both_mem5", {16'h0, mem[5]}, 32'h00001234);
        check("both_rd_kept", rd5, 32'hDEADBEEF);

        // Address 1023 wraps to the top SRAM word.
        run_access(1'b0, 1'b1, 32'd1023, 32'hCAFEF00D, rdy_v, oe_v, we_v, a1, a3, rd5);
        check("wrap_addr_lo", {14'h0, a1}, 32'h3FFFE);
        check("wrap_addr_hi", {14'h0, a3}, 32'h3FFFF);
        check("wrap_mem_lo", {16'h0, mem[18'h3FFFE]}, 32'h0000F00D);
        check("wrap_mem_hi", {16'h0, mem[18'h3FFFF]}, 32'h0000CAFE);

        // Unaligned 1030 hits word 1.
        run_access(1'b1, 1'b0, 32'd1030, 32'h0, rdy_v, oe_v, we_v, a1, a3, rd5);
        check("unal_addr_lo", {14'h0, a1}, 32'd2);
        check("unal_addr_hi", {14'h0, a3}, 32'd3);
        check("unal_rd_data", rd5, 32'hDEADBEEF);

`ifdef MEM_ACCESS_CTRL_LAST_READ_EN
        // Repeat load of word 1: served from the buffer in cycle 0.
        MEM_R_EN = 1'b1; ALU_result = 32'd1028;
        #1;
        check("hit_ready", {31'h0, ready}, 32'd1);
        check("hit_oe_n", {31'h0, SRAM_OE_N}, 32'd1);
        check("hit_rd_data", rd_data, 32'hDEADBEEF);
        #1;
        MEM_R_EN = 1'b0;
        @(negedge clk);
        #1;
        check("hit_after_oe_n", {31'h0, SRAM_OE_N}, 32'd1);
        check("hit_after_ready", {31'h0, ready}, 32'd1);
        @(negedge clk);

        run_access(1'b0, 1'b1, 32'd1028, 32'h11112222, rdy_v, oe_v, we_v, a1, a3, rd5);
        check("inv_st_ready_vec", {26'h0, rdy_v}, 32'b100000);
        run_access(1'b1, 1'b0, 32'd1028, 32'h0, rdy_v, oe_v, we_v, a1, a3, rd5);
        check("inv_ld_ready_vec", {26'h0, rdy_v}, 32'b100000);
        check("inv_ld_oe_vec", {26'h0, oe_v}, 32'b100001);
        check("inv_ld_rd_data", rd5, 32'h11112222);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
